// File: rtl/multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm
//   Control unit for a multicycle MIPS datapath. A Moore FSM sequences every
//   instruction through fetch, decode, execute, memory and write-back steps
//   and drives the datapath's register enables, memory strobes and mux
//   selects. Memory reads take 1+MEM_WAIT cycles. Opcodes and R-type functs
//   the machine does not implement are trapped to the exception vector.
//
// Parameters
//   MEM_WAIT  extra wait cycles per memory read (>= 0)
//   ST_W      width of the state_dbg output
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   opcode, funct, zero      IR[31:26], IR[5:0], ALU zero flag
//   pc_load, mem_write,      register / memory strobes
//   ins_load, reg_write,
//   regA_load, regB_load,
//   aluout_load
//   mux_alusrcA/B, mux_IorD, datapath mux selects
//   mux_pcin, mux_regdst,
//   mux_mem2reg, alu_op
//   illegal_op               one-cycle pulse while in TRAP
//   state_dbg                current state encoding
// ---------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
    parameter int MEM_WAIT = 2,
    parameter int ST_W     = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      opcode,
    input  logic [5:0]      funct,
    input  logic            zero,
    output logic            pc_load,
    output logic            mem_write,
    output logic            ins_load,
    output logic            reg_write,
    output logic            regA_load,
    output logic            regB_load,
    output logic            aluout_load,
    output logic            mux_alusrcA,
    output logic [1:0]      mux_alusrcB,
    output logic [1:0]      mux_IorD,
    output logic [1:0]      mux_pcin,
    output logic [1:0]      mux_regdst,
    output logic [2:0]      mux_mem2reg,
    output logic [2:0]      alu_op,
    output logic            illegal_op,
    output logic [ST_W-1:0] state_dbg
);

    localparam int CNT_W = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_WAIT);

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;
    localparam logic [2:0] ALU_SLT  = 3'd7;

    typedef enum logic [4:0] {
        S_RST     = 5'd0,
        S_INIT    = 5'd1,
        S_FETCH   = 5'd2,
        S_WAIT    = 5'd3,
        S_LATCH   = 5'd4,
        S_DECODE  = 5'd5,
        S_R_EXEC  = 5'd6,
        S_R_WB    = 5'd7,
        S_I_EXEC  = 5'd8,
        S_I_WB    = 5'd9,
        S_ADDR    = 5'd10,
        S_MEM_WR  = 5'd11,
        S_MEM_RD  = 5'd12,
        S_RD_WAIT = 5'd13,
        S_LW_WB   = 5'd14,
        S_BR_EQ   = 5'd15,
        S_BR_NE   = 5'd16,
        S_JUMP    = 5'd17,
        S_TRAP    = 5'd18
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             r_legal;
    logic [2:0]       r_alu;

    // R-type funct decode: {legal, alu_op}
    function automatic logic [3:0] decode_funct(input logic [5:0] f);
        case (f)
            6'h20:   decode_funct = {1'b1, ALU_ADD};
            6'h22:   decode_funct = {1'b1, ALU_SUB};
            6'h24:   decode_funct = {1'b1, ALU_AND};
            6'h25:   decode_funct = {1'b1, ALU_OR};
            6'h2A:   decode_funct = {1'b1, ALU_SLT};
            default: decode_funct = {1'b0, ALU_PASS};
        endcase
    endfunction

    assign {r_legal, r_alu} = decode_funct(funct);
    assign state_dbg        = ST_W'(state);

    // State and wait-counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RST;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic. FETCH and MEM_RD load the counter; the wait states
    // count it down and leave when it reaches 1, never decrementing past 0.
    always_comb begin
        state_next = S_FETCH;
        cnt_next   = cnt;
        case (state)
            S_RST:    state_next = S_INIT;
            S_INIT:   state_next = S_FETCH;
            S_FETCH: begin
                cnt_next   = CNT_INIT;
                state_next = (MEM_WAIT > 0) ? S_WAIT : S_LATCH;
            end
            S_WAIT: begin
                cnt_next   = (cnt != '0) ? cnt - 1'b1 : '0;
                state_next = (cnt <= CNT_W'(1)) ? S_LATCH : S_WAIT;
            end
            S_LATCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    6'h00:        state_next = S_R_EXEC;
                    6'h08:        state_next = S_I_EXEC;
                    6'h23, 6'h2B: state_next = S_ADDR;
                    6'h04:        state_next = S_BR_EQ;
                    6'h05:        state_next = S_BR_NE;
                    6'h02:        state_next = S_JUMP;
                    default:      state_next = S_TRAP;
                endcase
            end
            S_R_EXEC: state_next = r_legal ? S_R_WB : S_TRAP;
            S_R_WB:   state_next = S_FETCH;
            S_I_EXEC: state_next = S_I_WB;
            S_I_WB:   state_next = S_FETCH;
            S_ADDR:   state_next = (opcode == 6'h2B) ? S_MEM_WR : S_MEM_RD;
            S_MEM_WR: state_next = S_FETCH;
            S_MEM_RD: begin
                cnt_next   = CNT_INIT;
                state_next = (MEM_WAIT > 0) ? S_RD_WAIT : S_LW_WB;
            end
            S_RD_WAIT: begin
                cnt_next   = (cnt != '0) ? cnt - 1'b1 : '0;
                state_next = (cnt <= CNT_W'(1)) ? S_LW_WB : S_RD_WAIT;
            end
            S_LW_WB:  state_next = S_FETCH;
            S_BR_EQ:  state_next = S_FETCH;
            S_BR_NE:  state_next = S_FETCH;
            S_JUMP:   state_next = S_FETCH;
            S_TRAP:   state_next = S_FETCH;
            default:  state_next = S_FETCH;
        endcase
    end

    // Output decode from the current state; only the branch states look at
    // the zero flag. Unreachable encodings fall through to all-zero outputs.
    always_comb begin
        pc_load     = 1'b0;
        mem_write   = 1'b0;
        ins_load    = 1'b0;
        reg_write   = 1'b0;
        regA_load   = 1'b0;
        regB_load   = 1'b0;
        aluout_load = 1'b0;
        mux_alusrcA = 1'b0;
        mux_alusrcB = 2'd0;
        mux_IorD    = 2'd0;
        mux_pcin    = 2'd0;
        mux_regdst  = 2'd0;
        mux_mem2reg = 3'd0;
        alu_op      = ALU_PASS;
        illegal_op  = 1'b0;
        case (state)
            S_INIT: begin
                reg_write   = 1'b1;
                mux_regdst  = 2'd2;
                mux_mem2reg = 3'd6;
            end
            S_FETCH, S_WAIT: begin
                mux_IorD    = 2'd0;
                mux_alusrcA = 1'b0;
                mux_alusrcB = 2'd1;
                alu_op      = ALU_ADD;
            end
            S_LATCH: begin
                ins_load = 1'b1;
                pc_load  = 1'b1;
                mux_pcin = 2'd0;
            end
            S_DECODE: begin
                mux_alusrcA = 1'b0;
                mux_alusrcB = 2'd3;
                alu_op      = ALU_ADD;
                aluout_load = 1'b1;
                regA_load   = 1'b1;
                regB_load   = 1'b1;
            end
            S_R_EXEC: begin
                mux_alusrcA = 1'b1;
                mux_alusrcB = 2'd0;
                alu_op      = r_alu;
                aluout_load = r_legal;
            end
            S_R_WB: begin
                reg_write   = 1'b1;
                mux_regdst  = 2'd1;
                mux_mem2reg = 3'd0;
            end
            S_I_EXEC, S_ADDR: begin
                mux_alusrcA = 1'b1;
                mux_alusrcB = 2'd2;
                alu_op      = ALU_ADD;
                aluout_load = 1'b1;
            end
            S_I_WB: begin
                reg_write   = 1'b1;
                mux_regdst  = 2'd0;
                mux_mem2reg = 3'd0;
            end
            S_MEM_WR: begin
                mux_IorD  = 2'd1;
                mem_write = 1'b1;
            end
            S_MEM_RD, S_RD_WAIT: begin
                mux_IorD = 2'd1;
            end
            S_LW_WB: begin
                mux_IorD    = 2'd1;
                reg_write   = 1'b1;
                mux_regdst  = 2'd0;
                mux_mem2reg = 3'd1;
            end
            S_BR_EQ, S_BR_NE: begin
                mux_alusrcA = 1'b1;
                mux_alusrcB = 2'd0;
                alu_op      = ALU_SUB;
                mux_pcin    = 2'd1;
                pc_load     = (state == S_BR_EQ) ? zero : ~zero;
            end
            S_JUMP: begin
                pc_load  = 1'b1;
                mux_pcin = 2'd2;
            end
            S_TRAP: begin
                illegal_op = 1'b1;
                pc_load    = 1'b1;
                mux_pcin   = 2'd3;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl_fsm
//   Scoreboard bench for multicycle_ctrl_fsm. Two instances: dut (MEM_WAIT=2)
//   and dut0 (MEM_WAIT=0). Stimulus pushes the expected per-cycle output
//   vector for each instruction into a queue; the monitor pops one entry per
//   falling edge (or on demand right after an asynchronous reset) and
//   compares it to the instance's outputs.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rst0;
    logic [5:0] opcode, funct, opcode0, funct0;
    logic       zero, zero0;

    logic       pc_load, mem_write, ins_load, reg_write, regA_load, regB_load, aluout_load;
    logic       mux_alusrcA, illegal_op;
    logic [1:0] mux_alusrcB, mux_IorD, mux_pcin, mux_regdst;
    logic [2:0] mux_mem2reg, alu_op;
    logic [4:0] state_dbg;

    logic       pc_load0, mem_write0, ins_load0, reg_write0, regA_load0, regB_load0, aluout_load0;
    logic       mux_alusrcA0, illegal_op0;
    logic [1:0] mux_alusrcB0, mux_IorD0, mux_pcin0, mux_regdst0;
    logic [2:0] mux_mem2reg0, alu_op0;
    logic [4:0] state_dbg0;

    multicycle_ctrl_fsm #(.MEM_WAIT(2), .ST_W(5)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_load(pc_load), .mem_write(mem_write), .ins_load(ins_load),
        .reg_write(reg_write), .regA_load(regA_load), .regB_load(regB_load),
        .aluout_load(aluout_load), .mux_alusrcA(mux_alusrcA),
        .mux_alusrcB(mux_alusrcB), .mux_IorD(mux_IorD), .mux_pcin(mux_pcin),
        .mux_regdst(mux_regdst), .mux_mem2reg(mux_mem2reg), .alu_op(alu_op),
        .illegal_op(illegal_op), .state_dbg(state_dbg)
    );

    multicycle_ctrl_fsm #(.MEM_WAIT(0), .ST_W(5)) dut0 (
        .clk(clk), .rst(rst0), .opcode(opcode0), .funct(funct0), .zero(zero0),
        .pc_load(pc_load0), .mem_write(mem_write0), .ins_load(ins_load0),
        .reg_write(reg_write0), .regA_load(regA_load0), .regB_load(regB_load0),
        .aluout_load(aluout_load0), .mux_alusrcA(mux_alusrcA0),
        .mux_alusrcB(mux_alusrcB0), .mux_IorD(mux_IorD0), .mux_pcin(mux_pcin0),
        .mux_regdst(mux_regdst0), .mux_mem2reg(mux_mem2reg0), .alu_op(alu_op0),
        .illegal_op(illegal_op0), .state_dbg(state_dbg0)
    );

    // Vector: {pc,mw,il,rw,ra,rb,al,srcA,srcB[2],IorD[2],pcin[2],regdst[2],mem2reg[3],alu_op[3],ill}
    logic [22:0] q[$];
    logic [22:0] q0[$];
    string       qn[$];
    string       qn0[$];
    int          checks = 0;
    int          errors = 0;
    bit          done   = 1'b0;
    event        chk_ev;

    function automatic logic [22:0] mk(input int pc, input int mw, input int il, input int rw,
                                       input int ra, input int rb, input int al, input int sa,
                                       input int sb, input int iod, input int pcin, input int rdst,
                                       input int m2r, input int aop, input int ill);
        return {1'(pc), 1'(mw), 1'(il), 1'(rw), 1'(ra), 1'(rb), 1'(al), 1'(sa),
                2'(sb), 2'(iod), 2'(pcin), 2'(rdst), 3'(m2r), 3'(aop), 1'(ill)};
    endfunction

    task automatic push(input bit sel, input logic [22:0] v, input string nm);
        if (sel) begin
            q0.push_back(v);
            qn0.push_back(nm);
        end else begin
            q.push_back(v);
            qn.push_back(nm);
        end
    endtask

    // Issue one instruction starting in FETCH; lim>0 stops after that many cycles.
    task automatic issue(input bit sel, input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input int lim, input string tag);
        logic [22:0] s[$];
        string       sn[$];
        int          w;
        int          n;
        int          aop;
        int          pcl;
        bit          legal;
        w = sel ? 0 : 2;
        if (sel) begin
            opcode0 = op; funct0 = fn; zero0 = z;
        end else begin
            opcode = op; funct = fn; zero = z;
        end
        for (int i = 0; i <= w; i++) begin
            s.push_back(mk(0,0,0,0,0,0,0,0,1,0,0,0,0,1,0)); sn.push_back({tag, ".fetch"});
        end
        s.push_back(mk(1,0,1,0,0,0,0,0,0,0,0,0,0,0,0)); sn.push_back({tag, ".latch"});
        s.push_back(mk(0,0,0,0,1,1,1,0,3,0,0,0,0,1,0)); sn.push_back({tag, ".decode"});
        case (op)
            6'h00: begin
                legal = 1'b1;
                case (fn)
                    6'h20:   aop = 1;
                    6'h22:   aop = 2;
                    6'h24:   aop = 3;
                    6'h25:   aop = 4;
                    6'h2A:   aop = 7;
                    default: begin aop = 0; legal = 1'b0; end
                endcase
                if (legal) begin
                    s.push_back(mk(0,0,0,0,0,0,1,1,0,0,0,0,0,aop,0)); sn.push_back({tag, ".r_exec"});
                    s.push_back(mk(0,0,0,1,0,0,0,0,0,0,0,1,0,0,0)); sn.push_back({tag, ".r_wb"});
                end else begin
                    s.push_back(mk(0,0,0,0,0,0,0,1,0,0,0,0,0,0,0)); sn.push_back({tag, ".r_exec"});
                    s.push_back(mk(1,0,0,0,0,0,0,0,0,0,3,0,0,0,1)); sn.push_back({tag, ".trap"});
                end
            end
            6'h08: begin
                s.push_back(mk(0,0,0,0,0,0,1,1,2,0,0,0,0,1,0)); sn.push_back({tag, ".i_exec"});
                s.push_back(mk(0,0,0,1,0,0,0,0,0,0,0,0,0,0,0)); sn.push_back({tag, ".i_wb"});
            end
            6'h23: begin
                s.push_back(mk(0,0,0,0,0,0,1,1,2,0,0,0,0,1,0)); sn.push_back({tag, ".addr"});
                for (int i = 0; i <= w; i++) begin
                    s.push_back(mk(0,0,0,0,0,0,0,0,0,1,0,0,0,0,0)); sn.push_back({tag, ".mem_rd"});
                end
                s.push_back(mk(0,0,0,1,0,0,0,0,0,1,0,0,1,0,0)); sn.push_back({tag, ".lw_wb"});
            end
            6'h2B: begin
                s.push_back(mk(0,0,0,0,0,0,1,1,2,0,0,0,0,1,0)); sn.push_back({tag, ".addr"});
                s.push_back(mk(0,1,0,0,0,0,0,0,0,1,0,0,0,0,0)); sn.push_back({tag, ".mem_wr"});
            end
            6'h04, 6'h05: begin
                pcl = ((op == 6'h04) == (z == 1'b1)) ? 1 : 0;
                s.push_back(mk(pcl,0,0,0,0,0,0,1,0,0,1,0,0,2,0)); sn.push_back({tag, ".branch"});
            end
            6'h02: begin
                s.push_back(mk(1,0,0,0,0,0,0,0,0,0,2,0,0,0,0)); sn.push_back({tag, ".jump"});
            end
            default: begin
                s.push_back(mk(1,0,0,0,0,0,0,0,0,0,3,0,0,0,1)); sn.push_back({tag, ".trap"});
            end
        endcase
        n = (lim > 0 && lim < s.size()) ? lim : s.size();
        for (int i = 0; i < n; i++) push(sel, s[i], sn[i]);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic release_rst(input bit sel);
        if (sel) rst0 = 1'b0;
        else     rst  = 1'b0;
        push(sel, '0, "rst_state");
        push(sel, mk(0,0,0,1,0,0,0,0,0,0,0,2,6,0,0), "init");
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Expect v this cycle, then assert reset mid-cycle and expect zeros at once.
    task automatic mid_reset(input logic [22:0] v, input string nm);
        push(1'b0, v, nm);
        @(negedge clk);
        #1;
        rst = 1'b1;
        push(1'b0, '0, {nm, ".async_rst"});
        #1;
        ->chk_ev;
        @(posedge clk);
        #1;
        push(1'b0, '0, {nm, ".rst_hold"});
        @(posedge clk);
        #1;
        release_rst(1'b0);
    endtask

    // Monitor: sole owner of the counters and of the summary line.
    initial begin
        logic [22:0] act;
        logic [22:0] exp_v;
        string       nm;
        forever begin
            @(negedge clk or chk_ev);
            if (q.size() > 0) begin
                exp_v = q.pop_front();
                nm    = qn.pop_front();
                act   = {pc_load, mem_write, ins_load, reg_write, regA_load, regB_load,
                         aluout_load, mux_alusrcA, mux_alusrcB, mux_IorD, mux_pcin,
                         mux_regdst, mux_mem2reg, alu_op, illegal_op};
                checks++;
                if (act !== exp_v) begin
                    errors++;
                    $display("FAIL %s dut got %h want %h", nm, act, exp_v);
                end
            end
            if (q0.size() > 0) begin
                exp_v = q0.pop_front();
                nm    = qn0.pop_front();
                act   = {pc_load0, mem_write0, ins_load0, reg_write0, regA_load0, regB_load0,
                         aluout_load0, mux_alusrcA0, mux_alusrcB0, mux_IorD0, mux_pcin0,
                         mux_regdst0, mux_mem2reg0, alu_op0, illegal_op0};
                checks++;
                if (act !== exp_v) begin
                    errors++;
                    $display("FAIL %s dut0 got %h want %h", nm, act, exp_v);
                end
            end
            if (done) begin
                checks++;
                if (q.size() != 0 || q0.size() != 0) begin
                    errors++;
                    $display("FAIL drain left %0d/%0d want 0/0", q.size(), q0.size());
                end
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        rst = 1'b1; rst0 = 1'b1;
        opcode = '0; funct = '0; zero = 1'b0;
        opcode0 = '0; funct0 = '0; zero0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        push(1'b0, '0, "in_reset");
        push(1'b1, '0, "in_reset0");
        @(posedge clk);
        #1;
        release_rst(1'b0);

        issue(1'b0, 6'h00, 6'h22, 1'b0, 0, "sub");
        issue(1'b0, 6'h00, 6'h20, 1'b0, 0, "add");
        issue(1'b0, 6'h00, 6'h24, 1'b1, 0, "and");
        issue(1'b0, 6'h00, 6'h25, 1'b0, 0, "or");
        issue(1'b0, 6'h00, 6'h2A, 1'b0, 0, "slt");
        issue(1'b0, 6'h08, 6'h00, 1'b0, 0, "addi");
        issue(1'b0, 6'h23, 6'h00, 1'b0, 0, "lw");
        issue(1'b0, 6'h2B, 6'h00, 1'b0, 0, "sw");
        issue(1'b0, 6'h04, 6'h00, 1'b1, 0, "beq_z1");
        issue(1'b0, 6'h04, 6'h00, 1'b0, 0, "beq_z0");
        issue(1'b0, 6'h05, 6'h00, 1'b1, 0, "bne_z1");
        issue(1'b0, 6'h05, 6'h00, 1'b0, 0, "bne_z0");
        issue(1'b0, 6'h02, 6'h00, 1'b1, 0, "j");
        issue(1'b0, 6'h3F, 6'h00, 1'b0, 0, "ill_op");
        issue(1'b0, 6'h00, 6'h07, 1'b0, 0, "ill_fn");

        // Reset in the middle of a store (state MEM_WR)
        issue(1'b0, 6'h2B, 6'h00, 1'b0, 6, "sw_cut");
        mid_reset(mk(0,1,0,0,0,0,0,0,0,1,0,0,0,0,0), "sw_cut.mem_wr");
        issue(1'b0, 6'h08, 6'h00, 1'b0, 0, "addi_after");

        // Reset while the fetch read is waiting (first WAIT cycle)
        issue(1'b0, 6'h00, 6'h20, 1'b0, 1, "wait_cut");
        mid_reset(mk(0,0,0,0,0,0,0,0,1,0,0,0,0,1,0), "wait_cut.wait");
        issue(1'b0, 6'h00, 6'h22, 1'b0, 0, "sub_after");
        push(1'b0, mk(0,0,0,0,0,0,0,0,1,0,0,0,0,1,0), "tail.fetch");

        // Zero-wait-state instance
        release_rst(1'b1);
        issue(1'b1, 6'h23, 6'h00, 1'b0, 0, "lw_w0");
        issue(1'b1, 6'h00, 6'h20, 1'b0, 0, "add_w0");
        issue(1'b1, 6'h05, 6'h00, 1'b0, 0, "bne_w0");
        push(1'b1, mk(0,0,0,0,0,0,0,0,1,0,0,0,0,1,0), "tail0.fetch");
        @(posedge clk);
        #1;
        done = 1'b1;
        forever @(posedge clk);
    end

endmodule
